// File: rtl/mdu_issue.sv
// Issue/response sequencer between the pipeline and a multi-cycle MDU: holds one M-extension op,
// short-circuits divide-by-zero and signed-overflow divides, and bounds the MDU wait.
module mdu_issue #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_op_i,
  input  logic [31:0] req_rs1_i,
  input  logic [31:0] req_rs2_i,
  input  logic [4:0]  req_rd_addr_i,
  input  logic        flush_i,
  output logic        mdu_valid_o,
  output logic [2:0]  mdu_op_o,
  output logic [31:0] mdu_rs1_o,
  output logic [31:0] mdu_rs2_o,
  input  logic        mdu_ready_i,
  input  logic [31:0] mdu_rd_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic [4:0]  rsp_rd_addr_o,
  output logic        rsp_err_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StResp, StDrain} state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] result_q, result_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        accept, timeout, rs2_zero, ovf, shortcut;
  logic [31:0] short_val;

  assign accept   = req_valid_i & (state_q == StIdle) & ~flush_i;
  assign timeout  = cnt_q >= CntLast;
  assign rs2_zero = req_rs2_i == 32'h0;
  // Signed overflow only exists for DIV/REM (op[0] clear among the divide ops).
  assign ovf      = ~req_op_i[0] & (req_rs1_i == 32'h8000_0000) & (req_rs2_i == 32'hFFFF_FFFF);
  assign shortcut = req_op_i[2] & (rs2_zero | ovf);

  always_comb begin
    if (rs2_zero) short_val = req_op_i[1] ? req_rs1_i : 32'hFFFF_FFFF;
    else          short_val = req_op_i[1] ? 32'h0 : 32'h8000_0000;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = shortcut ? StResp : StIssue;
      StIssue: state_d = flush_i ? StDrain : StWait;
      StWait: begin
        if (mdu_ready_i)  state_d = flush_i ? StIdle : StResp;
        else if (flush_i) state_d = StDrain;
        else if (timeout) state_d = StResp;
      end
      StResp:  if (flush_i || rsp_ready_i) state_d = StIdle;
      StDrain: if (mdu_ready_i || timeout) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    op_d     = op_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    result_d = result_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d     = req_op_i;
          rs1_d    = req_rs1_i;
          rs2_d    = req_rs2_i;
          rd_d     = req_rd_addr_i;
          result_d = short_val;
          err_d    = 1'b0;
          cnt_d    = '0;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 8'd1;
        if (mdu_ready_i && !flush_i) begin
          result_d = mdu_rd_i;
          err_d    = 1'b0;
        end else if (!mdu_ready_i && !flush_i && timeout) begin
          result_d = '0;
          err_d    = 1'b1;
        end
      end
      StDrain: cnt_d = cnt_q + 8'd1;
      default: ;
    endcase
  end

  always_comb begin
    req_ready_o   = state_q == StIdle;
    busy_o        = state_q != StIdle;
    mdu_valid_o   = state_q == StIssue;
    rsp_valid_o   = state_q == StResp;
    mdu_op_o      = op_q;
    mdu_rs1_o     = rs1_q;
    mdu_rs2_o     = rs2_q;
    rsp_data_o    = result_q;
    rsp_rd_addr_o = rd_q;
    rsp_err_o     = err_q;
  end

endmodule

// File: tb/tb_mdu_issue.sv
// Bench for mdu_issue: directed corner cases plus randomized ops against an architectural
// M-extension reference and a cycle-budgeted MDU responder.
module tb_mdu_issue;

  localparam int unsigned T = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [2:0]  req_op_i = '0;
  logic [31:0] req_rs1_i = '0, req_rs2_i = '0;
  logic [4:0]  req_rd_addr_i = '0;
  logic        flush_i = 1'b0;
  logic        mdu_valid_o;
  logic [2:0]  mdu_op_o;
  logic [31:0] mdu_rs1_o, mdu_rs2_o;
  logic        mdu_ready_i = 1'b0;
  logic [31:0] mdu_rd_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_data_o;
  logic [4:0]  rsp_rd_addr_o;
  logic        rsp_err_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail = 0;
  int mv_cnt = 0;

  mdu_issue #(.TIMEOUT_CYCLES(T)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_op_i      (req_op_i),
    .req_rs1_i     (req_rs1_i),
    .req_rs2_i     (req_rs2_i),
    .req_rd_addr_i (req_rd_addr_i),
    .flush_i       (flush_i),
    .mdu_valid_o   (mdu_valid_o),
    .mdu_op_o      (mdu_op_o),
    .mdu_rs1_o     (mdu_rs1_o),
    .mdu_rs2_o     (mdu_rs2_o),
    .mdu_ready_i   (mdu_ready_i),
    .mdu_rd_i      (mdu_rd_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_data_o    (rsp_data_o),
    .rsp_rd_addr_o (rsp_rd_addr_o),
    .rsp_err_o     (rsp_err_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mdu_valid_o) mv_cnt <= mv_cnt + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural RISC-V M-extension result.
  function automatic logic [31:0] mdu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'h0, a});
    ub  = longint'({32'h0, b});
    ia  = a;
    ib  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic is_short(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    if (op < 3'd4) return 1'b0;
    if (b == 0) return 1'b1;
    return (op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  task automatic accept_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
    check("req_ready_idle", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1;
    req_op_i = op;
    req_rs1_i = a;
    req_rs2_i = b;
    req_rd_addr_i = rd;
    tick();
    req_valid_i = 1'b0;
    req_rs1_i = $urandom;
    req_rs2_i = $urandom;
    req_op_i = 3'($urandom);
  endtask

  // d: WAIT cycle (1-based) in which the MDU pulses ready; d > T means never. bp: stall cycles.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int d, input int bp);
    logic [31:0] exp;
    logic sc, exp_err;
    int mv0;
    exp = mdu_ref(op, a, b);
    sc = is_short(op, a, b);
    exp_err = !sc && d > int'(T);
    mv0 = mv_cnt;
    accept_op(op, a, b, rd);
    if (!sc) begin
      check("issue_pulse", 32'(mdu_valid_o), 32'd1);
      tick();
      for (int w = 1; w <= int'(T); w++) begin
        check("wait_no_pulse", 32'(mdu_valid_o), 32'd0);
        check("wait_no_rsp", 32'(rsp_valid_o), 32'd0);
        check("wait_rs1_hold", mdu_rs1_o, a);
        check("wait_rs2_hold", mdu_rs2_o, b);
        check("wait_op_hold", 32'(mdu_op_o), 32'(op));
        if (w == d) begin
          mdu_ready_i = 1'b1;
          mdu_rd_i = exp;
          tick();
          mdu_ready_i = 1'b0;
          mdu_rd_i = $urandom;
          break;
        end
        tick();
      end
    end
    for (int k = 0; k <= bp; k++) begin
      check("rsp_valid", 32'(rsp_valid_o), 32'd1);
      check("rsp_data", rsp_data_o, exp_err ? 32'h0 : exp);
      check("rsp_err", 32'(rsp_err_o), 32'(exp_err));
      check("rsp_rd", 32'(rsp_rd_addr_o), 32'(rd));
      check("rsp_busy", 32'(busy_o), 32'd1);
      check("rsp_req_ready", 32'(req_ready_o), 32'd0);
      if (k == bp) rsp_ready_i = 1'b1;
      tick();
    end
    rsp_ready_i = 1'b0;
    check("post_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("post_req_ready", 32'(req_ready_o), 32'd1);
    check("mdu_pulse_count", 32'(mv_cnt - mv0), sc ? 32'd0 : 32'd1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_req_ready"}, 32'(req_ready_o), 32'd1);
    check({pfx, "_busy"}, 32'(busy_o), 32'd0);
    check({pfx, "_mdu_valid"}, 32'(mdu_valid_o), 32'd0);
    check({pfx, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
    check({pfx, "_rsp_err"}, 32'(rsp_err_o), 32'd0);
    check({pfx, "_rsp_data"}, rsp_data_o, 32'd0);
    check({pfx, "_mdu_op"}, 32'(mdu_op_o), 32'd0);
    check({pfx, "_mdu_rs1"}, mdu_rs1_o, 32'd0);
    check({pfx, "_mdu_rs2"}, mdu_rs2_o, 32'd0);
  endtask

  initial begin
    logic [2:0] op;
    logic [31:0] a, b;
    int r, d;

    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();
    check("first_cycle_ready", 32'(req_ready_o), 32'd1);

    // MUL on the MDU path, 10-cycle MDU.
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, 10, 0);
    // Shortcuts.
    do_op(3'd5, 32'hDEAD_BEEF, 32'd0, 5'd3, 1, 0);
    do_op(3'd6, 32'h0000_1234, 32'd0, 5'd4, 1, 0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 1, 0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 1, 0);
    // Backpressure on both paths.
    do_op(3'd7, 32'h55, 32'd0, 5'd7, 1, 5);
    do_op(3'd1, 32'h8000_0001, 32'h7FFF_FFFF, 5'd8, 3, 5);
    // Ready on the final permitted cycle, then a full timeout.
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, int'(T), 1);
    do_op(3'd2, 32'hFFFF_FFF0, 32'h10, 5'd11, int'(T) + 10, 2);

    // Flush in WAIT cycle 3, late MDU completion at WAIT cycle 20.
    accept_op(3'd0, 32'h1111, 32'h2222, 5'd12);
    tick();
    tick();
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    for (int c = 4; c < 20; c++) begin
      check("drain_no_rsp", 32'(rsp_valid_o), 32'd0);
      check("drain_busy", 32'(busy_o), 32'd1);
      check("drain_rs1_hold", mdu_rs1_o, 32'h1111);
      tick();
    end
    mdu_ready_i = 1'b1;
    mdu_rd_i = 32'hABCD;
    tick();
    mdu_ready_i = 1'b0;
    check("drain_exit_ready", 32'(req_ready_o), 32'd1);
    check("drain_exit_no_rsp", 32'(rsp_valid_o), 32'd0);

    // Flush in RESP drops the response.
    accept_op(3'd5, 32'h9, 32'h0, 5'd13);
    check("resp_before_flush", 32'(rsp_valid_o), 32'd1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("resp_flush_no_rsp", 32'(rsp_valid_o), 32'd0);
    check("resp_flush_idle", 32'(req_ready_o), 32'd1);

    // Flush together with MDU completion in WAIT.
    accept_op(3'd0, 32'h3, 32'h4, 5'd14);
    tick();
    flush_i = 1'b1;
    mdu_ready_i = 1'b1;
    tick();
    flush_i = 1'b0;
    mdu_ready_i = 1'b0;
    check("flush_ready_idle", 32'(req_ready_o), 32'd1);
    check("flush_ready_no_rsp", 32'(rsp_valid_o), 32'd0);

    // Flush in IDLE blocks acceptance; stray MDU ready in IDLE ignored.
    req_valid_i = 1'b1;
    req_op_i = 3'd0;
    flush_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    flush_i = 1'b0;
    check("idle_flush_blocks", 32'(busy_o), 32'd0);
    mdu_ready_i = 1'b1;
    tick();
    mdu_ready_i = 1'b0;
    check("stray_ready_busy", 32'(busy_o), 32'd0);
    check("stray_ready_rsp", 32'(rsp_valid_o), 32'd0);

    // Reset in the middle of WAIT.
    accept_op(3'd3, 32'h7777, 32'h8888, 5'd15);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check_reset_outputs("midwait_rst");
    rst_n = 1'b1;
    mdu_ready_i = 1'b1;
    tick();
    mdu_ready_i = 1'b0;
    check("post_rst_ready_ignored", 32'(busy_o), 32'd0);
    check("post_rst_no_rsp", 32'(rsp_valid_o), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom);
      a = $urandom;
      b = $urandom;
      r = $urandom_range(0, 7);
      if (r == 0) b = 32'h0;
      else if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (r == 2) b = 32'($urandom_range(1, 5));
      d = ($urandom_range(0, 9) == 0) ? int'(T) + 1 : int'($urandom_range(1, 12));
      do_op(op, a, b, 5'($urandom), d, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
